// File: rtl/i2c_reg_init_master.sv
// Write-only I2C master that walks a register table (subaddress + data per entry), checks
// every ACK, retries failed transactions and reports done / err with the failing index.
module i2c_reg_init_master #(
  parameter int unsigned CLK_DIV   = 500,
  parameter logic [6:0]  DEV_ADDR  = 7'h24,
  parameter int unsigned NUM_REGS  = 24,
  parameter bit          BURST     = 1'b1,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] tbl_idx,
  input  logic [7:0] tbl_sub,
  input  logic [7:0] tbl_data,
  output logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] err_idx
);

  localparam int unsigned QDiv     = CLK_DIV / 4;
  localparam int unsigned CntW     = (QDiv > 1) ? $clog2(QDiv) : 1;
  localparam int unsigned RetryW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [7:0]  AddrByte = {DEV_ADDR, 1'b0};
  localparam logic [7:0]  LastIdx  = 8'(NUM_REGS - 1);
  localparam logic [CntW-1:0]   CntMax   = CntW'(QDiv - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StAckA, StSub, StAckS, StData, StAckD,
    StStop, StHold, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        q_q, q_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              ack_q, ack_d;
  logic              last_q, last_d;
  logic              fail_q, fail_d;
  logic [7:0]        tbl_idx_q, tbl_idx_d;
  logic [7:0]        err_idx_q, err_idx_d;
  logic              scl_q, scl_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       tick, active;
  logic       at_q0, at_q1, at_q2, at_q3;
  logic       load;
  logic [7:0] load_byte;

  assign active = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
  assign tick   = active && (cnt_q == CntMax);
  assign at_q0  = tick && (q_q == 2'd0);
  assign at_q1  = tick && (q_q == 2'd1);
  assign at_q2  = tick && (q_q == 2'd2);
  assign at_q3  = tick && (q_q == 2'd3);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    retry_d   = retry_q;
    ack_d     = ack_q;
    last_d    = last_q;
    fail_d    = fail_q;
    tbl_idx_d = tbl_idx_q;
    err_idx_d = err_idx_q;
    scl_d     = scl_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    load      = 1'b0;
    load_byte = 8'h00;

    if (active) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
      if (tick) q_d = q_q + 2'd1;
      if (at_q0) scl_d = 1'b1;
      // SCL stays high from the STOP rising edge through the idle hold period
      if (at_q2 && (state_q != StStop) && (state_q != StHold)) scl_d = 1'b0;
    end else begin
      cnt_d    = '0;
      q_d      = 2'd0;
      scl_d    = 1'b1;
      sda_oe_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StStart;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          retry_d = '0;
          last_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      StStart: begin
        if (at_q1) sda_oe_d = 1'b1;
        if (at_q3) begin
          state_d   = StAddr;
          load      = 1'b1;
          load_byte = AddrByte;
        end
      end
      StAddr, StSub, StData: begin
        if (at_q3) begin
          if (bit_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = (state_q == StAddr) ? StAckA :
                       (state_q == StSub)  ? StAckS : StAckD;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            bit_d    = bit_q - 3'd1;
            sda_oe_d = ~shift_q[6];
          end
        end
      end
      StAckA, StAckS, StAckD: begin
        if (at_q1) begin
          ack_d = ~sda_i;
          if (sda_i) begin
            if (retry_q == RetryMax) fail_d = 1'b1;
            else                     retry_d = retry_q + RetryW'(1);
          end else if (state_q == StAckD) begin
            // Advance here so tbl_data has settled before the next byte loads at q3
            retry_d = '0;
            if (tbl_idx_q == LastIdx) last_d = 1'b1;
            else                      tbl_idx_d = tbl_idx_q + 8'd1;
          end
        end
        if (at_q3) begin
          if (!ack_q) begin
            state_d  = StStop;
            sda_oe_d = 1'b1;
          end else if (state_q == StAckA) begin
            state_d   = StSub;
            load      = 1'b1;
            load_byte = tbl_sub;
          end else if ((state_q == StAckS) || (BURST && !last_q)) begin
            state_d   = StData;
            load      = 1'b1;
            load_byte = tbl_data;
          end else begin
            state_d  = StStop;
            sda_oe_d = 1'b1;
          end
        end
      end
      StStop: begin
        if (at_q1) sda_oe_d = 1'b0;
        if (at_q3) state_d = StHold;
      end
      StHold: begin
        if (at_q3) begin
          if (fail_q) begin
            state_d   = StErr;
            err_d     = 1'b1;
            err_idx_d = tbl_idx_q;
            busy_d    = 1'b0;
            tbl_idx_d = 8'd0;
          end else if (last_q) begin
            state_d   = StDone;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            tbl_idx_d = 8'd0;
          end else begin
            state_d = StStart;
          end
        end
      end
      StDone, StErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase

    if (load) begin
      shift_d  = load_byte;
      bit_d    = 3'd7;
      sda_oe_d = ~load_byte[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      q_q       <= 2'd0;
      shift_q   <= 8'h00;
      bit_q     <= 3'd0;
      retry_q   <= '0;
      ack_q     <= 1'b0;
      last_q    <= 1'b0;
      fail_q    <= 1'b0;
      tbl_idx_q <= 8'd0;
      err_idx_q <= 8'd0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      retry_q   <= retry_d;
      ack_q     <= ack_d;
      last_q    <= last_d;
      fail_q    <= fail_d;
      tbl_idx_q <= tbl_idx_d;
      err_idx_q <= err_idx_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tbl_idx = tbl_idx_q;
  assign err_idx = err_idx_q;
  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_i2c_reg_init_master.sv
// Bench for i2c_reg_init_master: ACK/NACK slave + bus decoder compared against a
// transaction-level model of the table walk, retries and completion flags.
module tb_i2c_reg_init_master;

  localparam int unsigned ClkDiv   = 8;
  localparam int unsigned NumRegs  = 3;
  localparam int unsigned MaxRetry = 3;
  localparam bit          Burst    = 1'b1;
  localparam int          Half     = ClkDiv / 2;
  localparam int          AddrWr   = 'h48;
  localparam int          EvStart  = 256;
  localparam int          EvStop   = 257;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tbl_idx, tbl_sub, tbl_data, err_idx;
  logic       scl, sda_i, sda_oe, busy, done, err;
  logic       slv_drv = 1'b0;

  logic [7:0] sub_mem  [256];
  logic [7:0] data_mem [256];
  bit         nack_set [1024];
  bit         nack_addr_perm = 1'b0;
  bit         mon_clr = 1'b0;

  assign tbl_sub  = sub_mem[tbl_idx];
  assign tbl_data = data_mem[tbl_idx];
  assign sda_i    = ~(sda_oe | slv_drv);

  i2c_reg_init_master #(
    .CLK_DIV  (ClkDiv),
    .DEV_ADDR (7'h24),
    .NUM_REGS (NumRegs),
    .BURST    (Burst),
    .MAX_RETRY(MaxRetry)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tbl_idx (tbl_idx),
    .tbl_sub (tbl_sub),
    .tbl_data(tbl_data),
    .scl     (scl),
    .sda_i   (sda_i),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_idx (err_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit nack_at(input int g);
    return (g >= 0 && g < 1024) ? nack_set[g] : 1'b0;
  endfunction

  // Bus decoder and slave
  int         ev_q[$];
  int         exp_q[$];
  int         bitn = 0, mon_gb = 0, mon_txb = 0, rises = 0;
  int         hi_len = 0, lo_len = 0, len_bad = 0, first_start_cyc = 0;
  bit         in_ack = 1'b0, hi_ok = 1'b0, got_start = 1'b0;
  logic [7:0] shreg = 8'h00;
  logic       scl_p = 1'b1, sda_p = 1'b1;

  always @(negedge clk) begin
    scl_p <= scl;
    sda_p <= sda_i;
    if (mon_clr) begin
      ev_q.delete();
      bitn <= 0; in_ack <= 1'b0; slv_drv <= 1'b0; mon_gb <= 0; mon_txb <= 0;
      rises <= 0; len_bad <= 0; got_start <= 1'b0; hi_ok <= 1'b0;
      hi_len <= 0; lo_len <= 0; first_start_cyc <= 0;
    end else begin
      if (scl) hi_len <= hi_len + 1;
      else     lo_len <= lo_len + 1;
      if (scl_p && scl && (sda_i != sda_p)) begin
        hi_ok <= 1'b0;
        if (!sda_i) begin
          ev_q.push_back(EvStart);
          bitn <= 0; in_ack <= 1'b0; slv_drv <= 1'b0; mon_txb <= 0;
          if (!got_start) begin
            got_start       <= 1'b1;
            first_start_cyc <= cyc;
          end
        end else begin
          ev_q.push_back(EvStop);
        end
      end
      if (!scl_p && scl) begin
        rises  <= rises + 1;
        hi_len <= 1;
        hi_ok  <= 1'b1;
        if (lo_len != Half) len_bad <= len_bad + 1;
        if (bitn < 8) begin
          shreg <= {shreg[6:0], sda_i};
          bitn  <= bitn + 1;
        end
      end
      if (scl_p && !scl) begin
        lo_len <= 1;
        if (hi_ok && hi_len != Half) len_bad <= len_bad + 1;
        if (in_ack) begin
          slv_drv <= 1'b0; in_ack <= 1'b0; bitn <= 0;
        end else if (bitn == 8) begin
          ev_q.push_back(int'(shreg));
          in_ack  <= 1'b1;
          slv_drv <= !(nack_at(mon_gb) || (nack_addr_perm && mon_txb == 0));
          mon_gb  <= mon_gb + 1;
          mon_txb <= mon_txb + 1;
        end
      end
    end
  end

  // Transaction-level expectation of the bus event stream and the final flags
  task automatic build_model(output int e_err, output int e_idx, output int e_rises);
    int idx = 0, retry = 0, gb = 0, nb = 0, ns = 0;
    bit fin = 1'b0, fail, more;
    exp_q.delete();
    e_err = 0;
    e_idx = 0;
    while (!fin) begin
      exp_q.push_back(EvStart);
      exp_q.push_back(AddrWr);
      fail = nack_at(gb) || nack_addr_perm;
      gb++; nb++;
      if (!fail) begin
        exp_q.push_back(int'(sub_mem[idx]));
        fail = nack_at(gb);
        gb++; nb++;
      end
      more = 1'b1;
      while (!fail && more) begin
        exp_q.push_back(int'(data_mem[idx]));
        fail = nack_at(gb);
        gb++; nb++;
        if (!fail) begin
          retry = 0;
          if (idx == NumRegs - 1) begin
            fin  = 1'b1;
            more = 1'b0;
          end else begin
            idx++;
            if (!Burst) more = 1'b0;
          end
        end
      end
      exp_q.push_back(EvStop);
      ns++;
      if (fail) begin
        if (retry == MaxRetry) begin
          fin   = 1'b1;
          e_err = 1;
          e_idx = idx;
        end else begin
          retry++;
        end
      end
    end
    e_rises = 9 * nb + ns;
  endtask

  task automatic clear_monitor();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic do_run(input string name, input bit keep_start, input bit already_busy);
    int e_err, e_idx, e_rises, busy_cyc, n;
    build_model(e_err, e_idx, e_rises);
    clear_monitor();
    busy_cyc = cyc;
    if (!already_busy) begin
      check_eq({name, ":busy_pre"}, int'(busy), 0);
      start = 1'b1;
      @(negedge clk);
      check_eq({name, ":busy_rise"}, int'(busy), 1);
      busy_cyc = cyc;
      if (!keep_start) start = 1'b0;
    end else begin
      start = 1'b0;
    end
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq({name, ":busy_fall"}, int'(busy), 0);
    check_eq({name, ":done"}, int'(done), e_err ? 0 : 1);
    check_eq({name, ":err"}, int'(err), e_err);
    if (e_err != 0) check_eq({name, ":err_idx"}, int'(err_idx), e_idx);
    check_eq({name, ":tbl_idx"}, int'(tbl_idx), 0);
    check_eq({name, ":scl_idle"}, int'(scl), 1);
    check_eq({name, ":sda_rel"}, int'(sda_oe), 0);
    check_eq({name, ":ev_count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      check_eq($sformatf("%s:ev%0d", name, i), ev_q[i], exp_q[i]);
      if (ev_q[i] != exp_q[i]) break;
    end
    check_eq({name, ":scl_rises"}, rises, e_rises);
    check_eq({name, ":scl_phase_len"}, len_bad, 0);
    if (!already_busy)
      check_eq({name, ":start_lat"},
               int'(got_start && (first_start_cyc - busy_cyc) <= int'(ClkDiv) + 1), 1);
  endtask

  task automatic set_fixed_table();
    sub_mem[0] = 8'h00; data_mem[0] = 8'h00;
    sub_mem[1] = 8'h01; data_mem[1] = 8'hC0;
    sub_mem[2] = 8'h02; data_mem[2] = 8'h23;
  endtask

  task automatic clear_nacks();
    for (int g = 0; g < 1024; g++) nack_set[g] = 1'b0;
    nack_addr_perm = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      sub_mem[i]  = 8'h00;
      data_mem[i] = 8'h00;
    end
    clear_nacks();
    set_fixed_table();

    repeat (3) @(negedge clk);
    check_eq("rst:scl", int'(scl), 1);
    check_eq("rst:sda_oe", int'(sda_oe), 0);
    check_eq("rst:busy", int'(busy), 0);
    check_eq("rst:done", int'(done), 0);
    check_eq("rst:err", int'(err), 0);
    check_eq("rst:err_idx", int'(err_idx), 0);
    check_eq("rst:tbl_idx", int'(tbl_idx), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run with start held high so DONE re-triggers a second run
    do_run("held1", 1'b1, 1'b0);
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("retrigger_gap", n, 2);
    check_eq("retrigger_done_clr", int'(done), 0);
    do_run("held2", 1'b0, 1'b1);

    // DATA of entry 1 NACKed once
    nack_set[3] = 1'b1;
    do_run("nack_data1", 1'b0, 1'b0);

    // Address NACKed permanently
    clear_nacks();
    nack_addr_perm = 1'b1;
    do_run("nack_addr", 1'b0, 1'b0);

    // Every byte from entry 1 DATA onward NACKed
    clear_nacks();
    for (int g = 3; g < 1024; g++) nack_set[g] = 1'b1;
    do_run("nack_tail", 1'b0, 1'b0);
    clear_nacks();

    // Reset in the middle of the SUB byte
    clear_monitor();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mon_gb >= 1 && bitn >= 3 && !in_ack) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_rst:reached_sub", int'(n < 2000), 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst:scl", int'(scl), 1);
    check_eq("mid_rst:sda_oe", int'(sda_oe), 0);
    check_eq("mid_rst:busy", int'(busy), 0);
    check_eq("mid_rst:tbl_idx", int'(tbl_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_run("after_rst", 1'b0, 1'b0);

    // Random tables and random NACK patterns
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NumRegs; i++) begin
        sub_mem[i]  = 8'($urandom_range(0, 255));
        data_mem[i] = 8'($urandom_range(0, 255));
      end
      clear_nacks();
      for (int g = 0; g < 64; g++) nack_set[g] = ($urandom_range(0, 9) == 0);
      do_run($sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
